// File: rtl/seg_scan_display_if.sv
// Data/control bundle between the debug-value source and the seven-segment scanner.
// The master drives the value to show; the slave returns the registered pin outputs.
interface seg_scan_display_if #(
   parameter int unsigned DIGITS = 4
);
   logic                  load;
   logic [4*DIGITS-1:0]   value;
   logic [DIGITS-1:0]     dots;
   logic                  blank_lz;
   logic                  blink_en;
   logic [6:0]            led;
   logic [DIGITS-1:0]     led_select;
   logic                  dot;
   logic                  frame_done;

   modport master (
      output load, value, dots, blank_lz, blink_en,
      input  led, led_select, dot, frame_done
   );

   modport slave (
      input  load, value, dots, blank_lz, blink_en,
      output led, led_select, dot, frame_done
   );
endinterface

// File: rtl/seg_scan_display.sv
// Multiplexed seven-segment scanner with frame-synchronous double-buffered data,
// leading-zero blanking, whole-display blinking and a frame strobe.
module seg_scan_display #(
   parameter int unsigned DIGITS         = 4,
   parameter int unsigned DIV            = 50000,
   parameter int unsigned BLINK_FRAMES   = 64,
   parameter bit          SEG_ACTIVE_LOW = 1'b1,
   parameter bit          SEL_ACTIVE_LOW = 1'b1
) (
   input logic               clk,
   input logic               reset,
   seg_scan_display_if.slave bus
);
   localparam int unsigned PRE_W = $clog2(DIV);
   localparam int unsigned IDX_W = $clog2(DIGITS);
   localparam int unsigned FC_W  = $clog2(BLINK_FRAMES + 1);
   localparam int unsigned VAL_W = 4 * DIGITS;

   logic [PRE_W-1:0]  r_pre,       w_pre_nxt;
   logic [IDX_W-1:0]  r_idx,       w_idx_nxt;
   logic [FC_W-1:0]   r_fcnt,      w_fcnt_nxt;
   logic              r_phase,     w_phase_nxt;
   logic              r_pend_v,    w_pend_v_nxt;
   logic [VAL_W-1:0]  r_pend_val,  w_pend_val_nxt;
   logic [DIGITS-1:0] r_pend_dots, w_pend_dots_nxt;
   logic [VAL_W-1:0]  r_act_val,   w_act_val_nxt;
   logic [DIGITS-1:0] r_act_dots,  w_act_dots_nxt;
   logic              r_bnd;
   logic [6:0]        r_led;
   logic [DIGITS-1:0] r_sel;
   logic              r_dot;
   logic              r_frame_done;

   logic              w_tick;
   logic              w_bnd;
   logic [3:0]        w_nib;
   logic              w_dp;
   logic              w_blank;
   logic              w_run;
   logic [DIGITS-1:0] w_zero_above;
   logic [DIGITS-1:0] w_onehot;
   logic [6:0]        w_seg;
   logic [DIGITS-1:0] w_sel;

   function automatic logic [6:0] hex7(input logic [3:0] n);
      case (n)
         4'h0:    hex7 = 7'h3F;
         4'h1:    hex7 = 7'h06;
         4'h2:    hex7 = 7'h5B;
         4'h3:    hex7 = 7'h4F;
         4'h4:    hex7 = 7'h66;
         4'h5:    hex7 = 7'h6D;
         4'h6:    hex7 = 7'h7D;
         4'h7:    hex7 = 7'h07;
         4'h8:    hex7 = 7'h7F;
         4'h9:    hex7 = 7'h6F;
         4'hA:    hex7 = 7'h77;
         4'hB:    hex7 = 7'h7C;
         4'hC:    hex7 = 7'h39;
         4'hD:    hex7 = 7'h5E;
         4'hE:    hex7 = 7'h79;
         default: hex7 = 7'h71;
      endcase
   endfunction

   assign w_tick = (r_pre == PRE_W'(DIV - 1));
   assign w_bnd  = w_tick && (r_idx == IDX_W'(DIGITS - 1));

   // Scan timing, blink phase and the pending/active double buffer
   always_comb begin
      w_pre_nxt       = w_tick ? '0 : r_pre + PRE_W'(1);
      w_idx_nxt       = r_idx;
      w_fcnt_nxt      = r_fcnt;
      w_phase_nxt     = r_phase;
      w_pend_v_nxt    = r_pend_v;
      w_pend_val_nxt  = r_pend_val;
      w_pend_dots_nxt = r_pend_dots;
      w_act_val_nxt   = r_act_val;
      w_act_dots_nxt  = r_act_dots;

      if (w_tick) begin
         w_idx_nxt = w_bnd ? '0 : r_idx + IDX_W'(1);
      end

      if (w_bnd) begin
         if (r_fcnt == FC_W'(BLINK_FRAMES - 1)) begin
            w_fcnt_nxt  = '0;
            w_phase_nxt = ~r_phase;
         end else begin
            w_fcnt_nxt  = r_fcnt + FC_W'(1);
         end
         // A load landing on the boundary is newer than anything pending
         if (bus.load) begin
            w_act_val_nxt  = bus.value;
            w_act_dots_nxt = bus.dots;
         end else if (r_pend_v) begin
            w_act_val_nxt  = r_pend_val;
            w_act_dots_nxt = r_pend_dots;
         end
         w_pend_v_nxt = 1'b0;
      end else if (bus.load) begin
         w_pend_val_nxt  = bus.value;
         w_pend_dots_nxt = bus.dots;
         w_pend_v_nxt    = 1'b1;
      end
   end

   // Segment/select pattern for the currently indexed digit (active-high)
   always_comb begin
      w_nib        = '0;
      w_dp         = 1'b0;
      w_blank      = 1'b0;
      w_run        = 1'b1;
      w_zero_above = '0;
      w_onehot     = '0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         w_run           = w_run && (r_act_val[4*i +: 4] == 4'h0);
         w_zero_above[i] = w_run;
      end
      for (int i = 0; i < DIGITS; i++) begin
         if (r_idx == IDX_W'(i)) begin
            w_nib       = r_act_val[4*i +: 4];
            w_dp        = r_act_dots[i];
            w_blank     = bus.blank_lz && (i != 0) && w_zero_above[i];
            w_onehot[i] = 1'b1;
         end
      end
      w_seg = w_blank ? 7'h00 : hex7(w_nib);
      w_sel = (bus.blink_en && r_phase) ? '0 : w_onehot;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pre        <= '0;
         r_idx        <= '0;
         r_fcnt       <= '0;
         r_phase      <= 1'b0;
         r_pend_v     <= 1'b0;
         r_pend_val   <= '0;
         r_pend_dots  <= '0;
         r_act_val    <= '0;
         r_act_dots   <= '0;
         r_bnd        <= 1'b0;
         r_led        <= {7{SEG_ACTIVE_LOW}};
         r_sel        <= {DIGITS{SEL_ACTIVE_LOW}};
         r_dot        <= SEG_ACTIVE_LOW;
         r_frame_done <= 1'b0;
      end else begin
         r_pre        <= w_pre_nxt;
         r_idx        <= w_idx_nxt;
         r_fcnt       <= w_fcnt_nxt;
         r_phase      <= w_phase_nxt;
         r_pend_v     <= w_pend_v_nxt;
         r_pend_val   <= w_pend_val_nxt;
         r_pend_dots  <= w_pend_dots_nxt;
         r_act_val    <= w_act_val_nxt;
         r_act_dots   <= w_act_dots_nxt;
         // Delayed once so the strobe lines up with digit 0 of the new frame
         r_bnd        <= w_bnd;
         r_led        <= w_seg ^ {7{SEG_ACTIVE_LOW}};
         r_sel        <= w_sel ^ {DIGITS{SEL_ACTIVE_LOW}};
         r_dot        <= w_dp ^ SEG_ACTIVE_LOW;
         r_frame_done <= r_bnd;
      end
   end

   assign bus.led        = r_led;
   assign bus.led_select = r_sel;
   assign bus.dot        = r_dot;
   assign bus.frame_done = r_frame_done;
endmodule

// File: tb/tb_seg_scan_display.sv
// Bench for seg_scan_display: directed scenarios plus random loads, checked every
// cycle against a reference derived from the edge count since reset release.
module tb_seg_scan_display;
   localparam int unsigned DIGITS = 4;
   localparam int unsigned DIV    = 4;
   localparam int unsigned BF     = 2;
   localparam int unsigned FR     = DIGITS * DIV;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   seg_scan_display_if #(.DIGITS(DIGITS)) bus ();

   seg_scan_display #(
      .DIGITS(DIGITS), .DIV(DIV), .BLINK_FRAMES(BF),
      .SEG_ACTIVE_LOW(1'b1), .SEL_ACTIVE_LOW(1'b1)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   logic [6:0] hex_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   int          n_vec  = 0;
   int          n_miss = 0;
   int          k;                 // clock edges since reset release
   logic [15:0] m_act;
   logic [3:0]  m_act_dots;
   logic [15:0] m_pend_val;
   logic [3:0]  m_pend_dots;
   bit          m_pend_v;
   int          m_pend_frame;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      assert (got === exp) else begin
         n_miss++;
         $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, got, exp, k);
      end
   endtask

   task automatic check_reset_vals();
      check("rst_led",  32'(bus.led),        32'h7F);
      check("rst_sel",  32'(bus.led_select), 32'hF);
      check("rst_dot",  32'(bus.dot),        32'h1);
      check("rst_fd",   32'(bus.frame_done), 32'h0);
   endtask

   task automatic model_reset();
      k          = 0;
      m_act      = '0;
      m_act_dots = '0;
      m_pend_v   = 1'b0;
   endtask

   // One clock: apply inputs, sample after the edge, compare with the model
   task automatic step(input bit ld, input logic [15:0] v, input logic [3:0] d);
      int          n, f, idx, phase;
      bit          bl, be, blank, fd;
      logic [15:0] upper;
      logic [6:0]  seg, e_led;
      logic [3:0]  e_sel, one;
      logic        e_dot;
      bus.load = ld;
      if (ld) begin
         bus.value = v;
         bus.dots  = d;
      end
      bl = bus.blank_lz;
      be = bus.blink_en;
      @(posedge clk);
      #1;
      k++;
      n     = k - 1;
      f     = n / FR;
      idx   = (n / DIV) % DIGITS;
      phase = (f / BF) % 2;
      if (m_pend_v && m_pend_frame <= f) begin
         m_act      = m_pend_val;
         m_act_dots = m_pend_dots;
         m_pend_v   = 1'b0;
      end
      upper = m_act >> (4 * idx);
      blank = bl && (idx > 0) && (upper == 16'h0);
      seg   = blank ? 7'h00 : hex_tbl[upper[3:0]];
      e_led = ~seg;
      one   = 4'(1) << idx;
      e_sel = (be && phase == 1) ? 4'hF : ~one;
      e_dot = ~m_act_dots[idx];
      fd    = (k > 1) && (n % FR == 0);
      check("led",        32'(bus.led),        32'(e_led));
      check("led_select", 32'(bus.led_select), 32'(e_sel));
      check("dot",        32'(bus.dot),        32'(e_dot));
      check("frame_done", 32'(bus.frame_done), 32'(fd));
      if (ld) begin
         m_pend_v     = 1'b1;
         m_pend_val   = v;
         m_pend_dots  = d;
         m_pend_frame = f + 1;
      end
      bus.load = 1'b0;
   endtask

   task automatic idle(input int cycles);
      for (int i = 0; i < cycles; i++) step(1'b0, 16'h0, 4'h0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] rv;
      bus.load     = 1'b0;
      bus.value    = '0;
      bus.dots     = '0;
      bus.blank_lz = 1'b0;
      bus.blink_en = 1'b0;
      model_reset();

      // Reset held across clock edges
      #2 reset = 1'b0;
      #21;
      check_reset_vals();
      @(negedge clk);
      reset = 1'b1;

      // First frames of zeros, then a load mid-frame at digit 1
      idle(20);
      step(1'b1, 16'h12AF, 4'b0100);
      idle(40);

      // Load coinciding with a frame boundary
      while ((k + 1) % FR != 0) step(1'b0, 16'h0, 4'h0);
      step(1'b1, 16'hBEEF, 4'b1010);
      idle(20);

      // Two loads in one frame: only the second is displayed
      while ((k + 1) % FR != 2) step(1'b0, 16'h0, 4'h0);
      step(1'b1, 16'h1111, 4'b0001);
      idle(4);
      step(1'b1, 16'h9C07, 4'b1000);
      idle(40);

      // Leading-zero blanking
      bus.blank_lz = 1'b1;
      step(1'b1, 16'h0030, 4'b0000);
      idle(40);
      step(1'b1, 16'h0000, 4'b0110);
      idle(40);
      bus.blank_lz = 1'b0;
      idle(8);

      // Blink, then drop blink_en mid-frame
      bus.blink_en = 1'b1;
      step(1'b1, 16'h4D2E, 4'b0011);
      idle(90);
      bus.blink_en = 1'b0;
      idle(12);

      // Random loads and level toggles
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(31) == 0) bus.blank_lz = ~bus.blank_lz;
         if ($urandom_range(63) == 0) bus.blink_en = ~bus.blink_en;
         if ($urandom_range(7) == 0) begin
            rv = 16'($urandom);
            case ($urandom_range(3))
               0:       rv = rv & 16'h00FF;
               1:       rv = rv & 16'h000F;
               2:       rv = 16'h0000;
               default: rv = rv;
            endcase
            step(1'b1, rv, 4'($urandom));
         end else begin
            step(1'b0, 16'h0, 4'h0);
         end
      end

      // Asynchronous reset between edges while a load is pending
      bus.blank_lz = 1'b0;
      bus.blink_en = 1'b0;
      while ((k + 1) % FR != 6) step(1'b0, 16'h0, 4'h0);
      step(1'b1, 16'h5A5A, 4'b1111);
      #2 reset = 1'b0;
      #1;
      check_reset_vals();
      @(negedge clk);
      reset = 1'b1;
      model_reset();
      idle(40);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
